// File: rtl/cook_pkg.sv
// Shared definitions for the microwave cook-time controller: state codes,
// BCD digit sizing and the seconds-tens saturation helper.
package cook_pkg;

  localparam int DIGIT_W = 4;
  localparam int ENTRY_W = 3 * DIGIT_W;
  localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_LOAD  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Keypad entry is free BCD; the seconds-tens counter is mod-6, so clamp it.
  function automatic logic [ENTRY_W-1:0] sat_time(input logic [ENTRY_W-1:0] e);
    logic [DIGIT_W-1:0] tens;
    tens = e[2*DIGIT_W-1:DIGIT_W];
    if (tens > MAX_SEC_TENS) tens = MAX_SEC_TENS;
    return {e[ENTRY_W-1:2*DIGIT_W], tens, e[DIGIT_W-1:0]};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to the one-second count enable. Counts only while enabled,
// holds its value otherwise so a paused cook resumes mid-second.
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (!clrn || clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + PW'(1);
    end
  end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad entry, timer-cascade load/clear, 1 Hz enable,
// and the cook/pause/done flow with door interlock and magnetron drive.
module cook_sequencer
  import cook_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clr,
  input  logic        door_closed,
  input  logic        all_zero,
  output logic [11:0] ld_data,
  output logic        cnt_loadn,
  output logic        cnt_clrn,
  output logic        cnt_en,
  output logic        mag_on,
  output logic        done,
  output logic [2:0]  state
);

  state_t             cur;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] entry_shift;
  logic               key_ok;
  logic               armed;
  logic               door_prev;
  logic               door_fall;
  logic               presc_en;
  logic               presc_clr;
  logic               tick;

  assign key_ok      = key_valid && (key_digit <= MAX_DIGIT);
  assign entry_shift = {entry[2*DIGIT_W-1:0], key_digit};
  assign door_fall   = door_prev && !door_closed;
  assign presc_en    = (cur == S_COOK) && door_closed && !stop_clr;
  assign presc_clr   = (cur == S_LOAD);
  assign state       = cur;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .clrn (clrn),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  // Strobe-style outputs default inactive each cycle; branches below pulse them.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      cur       <= S_IDLE;
      entry     <= '0;
      ld_data   <= '0;
      cnt_loadn <= 1'b1;
      cnt_clrn  <= 1'b0;
      cnt_en    <= 1'b0;
      mag_on    <= 1'b0;
      done      <= 1'b0;
      armed     <= 1'b0;
      door_prev <= 1'b0;
    end else begin
      cnt_loadn <= 1'b1;
      cnt_clrn  <= 1'b1;
      cnt_en    <= 1'b0;
      door_prev <= door_closed;

      case (cur)
        S_IDLE: begin
          if (key_ok) begin
            entry   <= entry_shift;
            ld_data <= sat_time(entry_shift);
            cur     <= S_SET;
          end
        end

        S_SET: begin
          if (stop_clr) begin
            entry   <= '0;
            ld_data <= '0;
            cur     <= S_IDLE;
          end else if (start && door_closed && (entry != '0)) begin
            cnt_loadn <= 1'b0;
            cur       <= S_LOAD;
          end else if (key_ok) begin
            entry   <= entry_shift;
            ld_data <= sat_time(entry_shift);
          end
        end

        S_LOAD: begin
          armed  <= 1'b0;
          mag_on <= 1'b1;
          cur    <= S_COOK;
        end

        // all_zero is stale on the first cycle after a load, hence the armed flag.
        S_COOK: begin
          if (!door_closed || stop_clr) begin
            mag_on <= 1'b0;
            cur    <= S_PAUSE;
          end else if (armed && all_zero) begin
            mag_on <= 1'b0;
            done   <= 1'b1;
            cur    <= S_DONE;
          end else begin
            armed  <= 1'b1;
            cnt_en <= tick;
          end
        end

        S_PAUSE: begin
          if (stop_clr) begin
            cnt_clrn <= 1'b0;
            entry    <= '0;
            ld_data  <= '0;
            cur      <= S_IDLE;
          end else if (start && door_closed) begin
            mag_on <= 1'b1;
            cur    <= S_COOK;
          end
        end

        S_DONE: begin
          if (key_ok || start || stop_clr || door_fall) begin
            done     <= 1'b0;
            cnt_clrn <= 1'b0;
            entry    <= '0;
            ld_data  <= '0;
            cur      <= S_IDLE;
          end
        end

        default: begin
          mag_on <= 1'b0;
          done   <= 1'b0;
          cur    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer with a behavioural model of the
// three external timer digits driving all_zero.
module tb_cook_sequencer;

  logic        clk;
  logic        clrn;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        start;
  logic        stop_clr;
  logic        door_closed;
  logic        all_zero;
  logic [11:0] ld_data;
  logic        cnt_loadn;
  logic        cnt_clrn;
  logic        cnt_en;
  logic        mag_on;
  logic        done;
  logic [2:0]  state;

  cook_sequencer #(
    .TICK_DIV(4)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop_clr    (stop_clr),
    .door_closed (door_closed),
    .all_zero    (all_zero),
    .ld_data     (ld_data),
    .cnt_loadn   (cnt_loadn),
    .cnt_clrn    (cnt_clrn),
    .cnt_en      (cnt_en),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External timer digits: min mod-10, sec tens mod-6, sec units mod-10.
  logic [3:0] t_min = 4'd0;
  logic [3:0] t_ten = 4'd0;
  logic [3:0] t_uni = 4'd0;
  assign all_zero = (t_min == 4'd0) && (t_ten == 4'd0) && (t_uni == 4'd0);

  always @(posedge clk) begin
    if (cnt_clrn === 1'b0) begin
      t_min <= 4'd0; t_ten <= 4'd0; t_uni <= 4'd0;
    end else if (cnt_loadn === 1'b0) begin
      t_min <= ld_data[11:8]; t_ten <= ld_data[7:4]; t_uni <= ld_data[3:0];
    end else if (cnt_en === 1'b1) begin
      if (t_uni != 4'd0) t_uni <= t_uni - 4'd1;
      else begin
        t_uni <= 4'd9;
        if (t_ten != 4'd0) t_ten <= t_ten - 4'd1;
        else begin
          t_ten <= 4'd5;
          t_min <= (t_min != 4'd0) ? t_min - 4'd1 : 4'd9;
        end
      end
    end
  end

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] ld;
    logic        loadn;
    logic        cclrn;
    logic        en;
    logic        mag;
    logic        dn;
  } exp_t;

  typedef struct packed {
    logic       rn;
    logic       kv;
    logic [3:0] kd;
    logic       go;
    logic       sc;
    logic       dr;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tab1[$];
  vec_t tab2[$];
  int compared = 0;
  int mismatched = 0;

  function automatic vec_t mk(input logic rn, input logic kv, input logic [3:0] kd,
                              input logic go, input logic sc, input logic dr,
                              input logic [2:0] st, input logic [11:0] ld,
                              input logic loadn, input logic cclrn, input logic en,
                              input logic mag, input logic dn);
    vec_t v;
    v.rn = rn; v.kv = kv; v.kd = kd; v.go = go; v.sc = sc; v.dr = dr;
    v.e.st = st; v.e.ld = ld; v.e.loadn = loadn; v.e.cclrn = cclrn;
    v.e.en = en; v.e.mag = mag; v.e.dn = dn;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: scoreboard empty, got state 0x%0h, expected an entry", tag, state);
      return;
    end
    e = exp_q.pop_front();
    checkValue({tag, ".state"},     32'(state),     32'(e.st));
    checkValue({tag, ".ld_data"},   32'(ld_data),   32'(e.ld));
    checkValue({tag, ".cnt_loadn"}, 32'(cnt_loadn), 32'(e.loadn));
    checkValue({tag, ".cnt_clrn"},  32'(cnt_clrn),  32'(e.cclrn));
    checkValue({tag, ".cnt_en"},    32'(cnt_en),    32'(e.en));
    checkValue({tag, ".mag_on"},    32'(mag_on),    32'(e.mag));
    checkValue({tag, ".done"},      32'(done),      32'(e.dn));
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    clrn = v.rn; key_valid = v.kv; key_digit = v.kd;
    start = v.go; stop_clr = v.sc; door_closed = v.dr;
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic driveIdle();
    clrn = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop_clr = 1'b0; door_closed = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int pulses;
    int next_tick;
    bit reached;

    clrn = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop_clr = 1'b0; door_closed = 1'b1;

    //          rn kv kd    go sc dr  st    ld       ln cn en mg dn
    tab1.push_back(mk(0, 0, 4'd0, 0, 0, 1, 3'd0, 12'h000, 1, 0, 0, 0, 0));
    tab1.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    tab1.push_back(mk(1, 1, 4'd1, 0, 0, 1, 3'd1, 12'h001, 1, 1, 0, 0, 0));
    tab1.push_back(mk(1, 1, 4'd3, 0, 0, 1, 3'd1, 12'h013, 1, 1, 0, 0, 0));
    tab1.push_back(mk(1, 1, 4'd0, 0, 0, 1, 3'd1, 12'h130, 1, 1, 0, 0, 0));
    tab1.push_back(mk(1, 0, 4'd0, 1, 0, 1, 3'd2, 12'h130, 0, 1, 0, 0, 0));
    tab1.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h130, 1, 1, 0, 1, 0));

    // DONE exit by key, then entry/saturation/ignored-start cases
    tab2.push_back(mk(1, 1, 4'd7, 0, 0, 1, 3'd0, 12'h000, 1, 0, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd12, 0, 0, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 1, 0, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd9, 0, 0, 1, 3'd1, 12'h009, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd9, 0, 0, 1, 3'd1, 12'h059, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd11, 0, 0, 1, 3'd1, 12'h059, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 1, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd1, 0, 0, 1, 3'd1, 12'h001, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd2, 0, 0, 1, 3'd1, 12'h012, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd3, 0, 0, 1, 3'd1, 12'h123, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd5, 0, 0, 1, 3'd1, 12'h235, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 1, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd2, 0, 0, 1, 3'd1, 12'h002, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 1, 0, 0, 3'd1, 12'h002, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 1, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd0, 0, 0, 1, 3'd1, 12'h000, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 1, 0, 1, 3'd1, 12'h000, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 1, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    // door opens with prescaler at 2, resume, stop+start together, clear
    tab2.push_back(mk(1, 1, 4'd5, 0, 0, 1, 3'd1, 12'h005, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 1, 4'd0, 0, 0, 1, 3'd1, 12'h050, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 1, 0, 1, 3'd2, 12'h050, 0, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h050, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h050, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h050, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 0, 3'd4, 12'h050, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 1, 0, 0, 3'd4, 12'h050, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd4, 12'h050, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 1, 0, 1, 3'd3, 12'h050, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h050, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h050, 1, 1, 1, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h050, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 1, 1, 1, 3'd4, 12'h050, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 1, 1, 3'd0, 12'h000, 1, 0, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    // reset asserted mid-cook
    tab2.push_back(mk(1, 1, 4'd1, 0, 0, 1, 3'd1, 12'h001, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 1, 0, 1, 3'd2, 12'h001, 0, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h001, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h001, 1, 1, 0, 1, 0));
    tab2.push_back(mk(0, 0, 4'd0, 0, 0, 1, 3'd0, 12'h000, 1, 0, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));
    // one-second cook ending in DONE, exit on door opening
    tab2.push_back(mk(1, 1, 4'd1, 0, 0, 1, 3'd1, 12'h001, 1, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 1, 0, 1, 3'd2, 12'h001, 0, 1, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h001, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h001, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h001, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h001, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h001, 1, 1, 1, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd3, 12'h001, 1, 1, 0, 1, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd5, 12'h001, 1, 1, 0, 0, 1));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd5, 12'h001, 1, 1, 0, 0, 1));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 0, 3'd0, 12'h000, 1, 0, 0, 0, 0));
    tab2.push_back(mk(1, 0, 4'd0, 0, 0, 1, 3'd0, 12'h000, 1, 1, 0, 0, 0));

    for (int i = 0; i < tab1.size(); i++)
      applyStimulus(tab1[i], $sformatf("t1r%0d", i));

    // 1:30 cook: one enable every 4 clocks, 90 enables, then DONE
    cyc = 0; pulses = 0; next_tick = 4; reached = 1'b0;
    for (int i = 0; i < 600 && !reached; i++) begin
      driveIdle();
      @(posedge clk);
      #1;
      cyc++;
      if (cnt_en === 1'b1) begin
        pulses++;
        checkValue($sformatf("tick%0d_cycle", pulses), 32'(cyc), 32'(next_tick));
        next_tick += 4;
      end
      if (state === 3'd5) reached = 1'b1;
    end
    checkValue("cook_done_state", 32'(state), 32'd5);
    checkValue("cook_done_cycle", 32'(cyc), 32'd362);
    checkValue("cook_tick_count", 32'(pulses), 32'd90);
    checkValue("cook_done_mag_on", 32'(mag_on), 32'd0);
    checkValue("cook_done_flag", 32'(done), 32'd1);
    checkValue("cook_done_ld_data", 32'(ld_data), 32'h130);

    for (int i = 0; i < tab2.size(); i++)
      applyStimulus(tab2[i], $sformatf("t2r%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
